// File: rtl/soc_board_pkg.sv
// Board-level constants and types shared by the DE10-Nano fabric helpers.
// Provides the fabric clock rate, a ms-to-cycles helper and the debouncer state type.
package soc_board_pkg;

    localparam int unsigned CLK_HZ = 50_000_000;

    // Number of fabric clock cycles in the given number of milliseconds.
    function automatic int unsigned ms_to_cycles(input int unsigned ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

    typedef enum logic {
        IDLE    = 1'b0,
        QUALIFY = 1'b1
    } deb_state_t;

endpackage

// File: rtl/switches_debouncer_if.sv
// Switch-conditioning bus between the pin side (master) and the debouncer (slave).
// Signal names match the debouncer's external port names.
interface switches_debouncer_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] sw_raw_i;
    logic [WIDTH-1:0] sw_debounced_o;
    logic [WIDTH-1:0] sw_rise_o;
    logic [WIDTH-1:0] sw_fall_o;
    logic             change_pending_o;
    logic             change_clear_i;

    modport master (
        output sw_raw_i,
        output change_clear_i,
        input  sw_debounced_o,
        input  sw_rise_o,
        input  sw_fall_o,
        input  change_pending_o
    );

    modport slave (
        input  sw_raw_i,
        input  change_clear_i,
        output sw_debounced_o,
        output sw_rise_o,
        output sw_fall_o,
        output change_pending_o
    );
endinterface

// File: rtl/switches_debouncer_bit.sv
// Single switch channel: input synchroniser, stability counter/FSM and registered edge pulses.
// A new level is accepted only after DEBOUNCE_CYCLES consecutive synced cycles.
module debounce_bit
    import soc_board_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 8,
    parameter logic        RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic debounced,
    output logic rise,
    output logic fall
);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    deb_state_t             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    assign sync = sync_q[SYNC_STAGES-1];

    // Metastability chain; the pin enters only at stage 0.
    always_ff @(posedge clk) begin
        if (!rst_n) sync_q <= {SYNC_STAGES{RESET_VAL}};
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end

    // State register: reset discards any qualification in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            stable_q <= RESET_VAL;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sync != stable_q) state_d = QUALIFY;
            QUALIFY: if ((sync == stable_q) || (cnt_q == CNT_MAX)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counter, accepted level and edge pulses; the count saturates at CNT_MAX by construction.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        case (state_q)
            IDLE: cnt_d = (sync != stable_q) ? CNT_W'(1) : '0;
            QUALIFY: begin
                if (sync == stable_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_MAX) begin
                    cnt_d    = '0;
                    stable_d = sync;
                    rise_d   = sync;
                    fall_d   = ~sync;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: cnt_d = '0;
        endcase
    end

    assign debounced = stable_q;
    assign rise      = rise_q;
    assign fall      = fall_q;

endmodule

// File: rtl/switches_debouncer.sv
// Debounces the slide-switch pins ahead of the switches PIO and raises a sticky change flag.
// Channels are independent; the top only owns the change-pending register.
module switches_debouncer
    import soc_board_pkg::*;
#(
    parameter int unsigned      WIDTH           = 4,
    parameter int unsigned      SYNC_STAGES     = 2,
    parameter int unsigned      DEBOUNCE_CYCLES = ms_to_cycles(20),
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset_n,
    switches_debouncer_if.slave  sw
);
    logic any_edge;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VAL       (RESET_VALUE[i])
        ) u_bit (
            .clk       (clk_clk),
            .rst_n     (reset_reset_n),
            .raw       (sw.sw_raw_i[i]),
            .debounced (sw.sw_debounced_o[i]),
            .rise      (sw.sw_rise_o[i]),
            .fall      (sw.sw_fall_o[i])
        );
    end

    assign any_edge = (|sw.sw_rise_o) | (|sw.sw_fall_o);

    // Sticky flag: a new edge wins over a simultaneous clear.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n)            sw.change_pending_o <= 1'b0;
        else if (any_edge)             sw.change_pending_o <= 1'b1;
        else if (sw.change_clear_i)    sw.change_pending_o <= 1'b0;
    end

endmodule
